// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the program-counter stage.
//   ADDR_W      : instruction address width
//   PC_STEP     : byte distance between sequential instructions
//   seq_state_t : sequencer state encoding (IDLE = 0, RUN = 1, STALL = 2)
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_target_adder.sv
// Modulo-2^W adder used for both PC+4 and the branch/jump target.
//   a, b : operands
//   sum  : a + b, carry discarded (silent wrap)
module pc_target_adder #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, PC+4 / target adders, next-PC select,
// BUSYWAIT freeze and performance counters.
//   CLK, RESET         : clock (rising edge), asynchronous active-high reset
//   SHIFTED_OFFSET     : signed branch/jump offset, already multiplied by 4
//   JUMP, BRANCH_EQ,
//   BRANCH_NE, ZERO    : control flags and ALU zero flag for current instr
//   BUSYWAIT           : memory stall request (level)
//   PC, PC_PLUS4       : current PC (registered) and PC + 4 (combinational)
//   INSTR_VALID        : current instruction retires at the next edge
//   REDIRECT           : next advancing edge loads the target
//   RETIRED_CNT, REDIRECT_CNT, STALL_CNT : wrapping performance counters
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned       CNT_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] SHIFTED_OFFSET,
    input  logic              JUMP,
    input  logic              BRANCH_EQ,
    input  logic              BRANCH_NE,
    input  logic              ZERO,
    input  logic              BUSYWAIT,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PC_PLUS4,
    output logic              INSTR_VALID,
    output logic              REDIRECT,
    output logic [CNT_W-1:0]  RETIRED_CNT,
    output logic [CNT_W-1:0]  REDIRECT_CNT,
    output logic [CNT_W-1:0]  STALL_CNT
);

    seq_state_t        state, state_next;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;
    logic              taken;
    logic              advance;
    logic              stalling;
    logic [CNT_W-1:0]  retired_q, redirect_q, stall_q;

    pc_target_adder #(.W(ADDR_W)) u_pc_inc (
        .a   (pc_q),
        .b   (PC_STEP),
        .sum (PC_PLUS4)
    );

    pc_target_adder #(.W(ADDR_W)) u_pc_tgt (
        .a   (PC_PLUS4),
        .b   (SHIFTED_OFFSET),
        .sum (target)
    );

    // Flags are evaluated at the advancing edge itself, so a branch decided
    // while BUSYWAIT is high is simply re-evaluated when the stall ends.
    always_comb begin
        taken      = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
        next_pc    = taken ? target : PC_PLUS4;
        state_next = state;
        advance    = 1'b0;
        stalling   = 1'b0;
        case (state)
            IDLE: begin
                state_next = RUN;
            end
            RUN, STALL: begin
                advance    = ~BUSYWAIT;
                stalling   = BUSYWAIT;
                state_next = BUSYWAIT ? STALL : RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        INSTR_VALID = advance;
        REDIRECT    = taken & (state != IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            retired_q  <= '0;
            redirect_q <= '0;
            stall_q    <= '0;
        end else begin
            state <= state_next;
            if (advance) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + CNT_W'(1);
                if (taken) begin
                    redirect_q <= redirect_q + CNT_W'(1);
                end
            end
            if (stalling) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign PC           = pc_q;
    assign RETIRED_CNT  = retired_q;
    assign REDIRECT_CNT = redirect_q;
    assign STALL_CNT    = stall_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] SHIFTED_OFFSET;
    logic        JUMP, BRANCH_EQ, BRANCH_NE, ZERO, BUSYWAIT;
    logic [31:0] PC, PC_PLUS4;
    logic        INSTR_VALID, REDIRECT;
    logic [31:0] RETIRED_CNT, REDIRECT_CNT, STALL_CNT;

    // small-counter instance for wrap checks
    logic        w_reset;
    logic [31:0] w_pc, w_pc_plus4;
    logic        w_iv, w_redir;
    logic [3:0]  w_ret, w_red, w_stl;

    int checks = 0;
    int passes = 0;

    // reference model state
    bit          m_idle;
    logic [31:0] m_pc, m_ret, m_red, m_stl;

    always #5 CLK = ~CLK;

    pc_sequencer #(.CNT_W(32), .RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RESET(RESET), .SHIFTED_OFFSET(SHIFTED_OFFSET),
        .JUMP(JUMP), .BRANCH_EQ(BRANCH_EQ), .BRANCH_NE(BRANCH_NE), .ZERO(ZERO),
        .BUSYWAIT(BUSYWAIT), .PC(PC), .PC_PLUS4(PC_PLUS4),
        .INSTR_VALID(INSTR_VALID), .REDIRECT(REDIRECT),
        .RETIRED_CNT(RETIRED_CNT), .REDIRECT_CNT(REDIRECT_CNT), .STALL_CNT(STALL_CNT)
    );

    pc_sequencer #(.CNT_W(4), .RESET_PC(32'h0000_0100)) dut_w (
        .CLK(CLK), .RESET(w_reset), .SHIFTED_OFFSET(32'd0),
        .JUMP(1'b1), .BRANCH_EQ(1'b0), .BRANCH_NE(1'b0), .ZERO(1'b0),
        .BUSYWAIT(1'b0), .PC(w_pc), .PC_PLUS4(w_pc_plus4),
        .INSTR_VALID(w_iv), .REDIRECT(w_redir),
        .RETIRED_CNT(w_ret), .REDIRECT_CNT(w_red), .STALL_CNT(w_stl)
    );

    typedef struct {
        logic        j, beq, bne, z, bw;
        logic [31:0] off;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_taken();
        return JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & !ZERO);
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_pc   = 32'h0;
        m_ret  = 32'h0;
        m_red  = 32'h0;
        m_stl  = 32'h0;
    endtask

    // one rising edge of the specification's rules, using the current inputs
    task automatic model_edge();
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (BUSYWAIT) begin
            m_stl = m_stl + 1;
        end else begin
            m_ret = m_ret + 1;
            if (model_taken()) begin
                m_red = m_red + 1;
                m_pc  = m_pc + 32'd4 + SHIFTED_OFFSET;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_now();
        chk("pc",          PC,                  m_pc);
        chk("pc_plus4",    PC_PLUS4,            m_pc + 32'd4);
        chk("instr_valid", {31'd0, INSTR_VALID}, {31'd0, !m_idle && !BUSYWAIT && !RESET});
        chk("redirect",    {31'd0, REDIRECT},    {31'd0, !m_idle && model_taken() && !RESET});
        chk("retired_cnt", RETIRED_CNT,         m_ret);
        chk("redirect_cnt", REDIRECT_CNT,       m_red);
        chk("stall_cnt",   STALL_CNT,           m_stl);
    endtask

    task automatic drive(input logic j, input logic beq, input logic bne,
                         input logic z, input logic bw, input logic [31:0] off);
        JUMP = j; BRANCH_EQ = beq; BRANCH_NE = bne; ZERO = z; BUSYWAIT = bw;
        SHIFTED_OFFSET = off;
    endtask

    // called at a negedge; returns at the following negedge
    task automatic tick();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        #1;
        check_now();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        RESET   = 1'b1;
        w_reset = 1'b1;
        drive(0, 0, 0, 0, 0, 32'd0);
        model_reset();

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd100,      32'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd4};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd8};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF4, 32'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd4};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,        32'd8};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF4, 32'd12};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        32'd16};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16,       32'd16};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16,       32'd16};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd16,       32'd16};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd16,       32'd36};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFD4, 32'hFFFF_FFFC};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8,        32'd8};

        // reset state, then the directed table (first row is the IDLE cycle)
        @(negedge CLK);
        #1;
        check_now();
        RESET = 1'b0;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].j, tbl[i].beq, tbl[i].bne, tbl[i].z, tbl[i].bw, tbl[i].off);
            #1;
            check_now();
            tick();
            chk($sformatf("tbl_pc[%0d]", i), PC, tbl[i].exp_pc);
        end
        chk("tbl_retired", RETIRED_CNT, 32'd10);
        chk("tbl_redirect", REDIRECT_CNT, 32'd5);
        chk("tbl_stall", STALL_CNT, 32'd3);

        // asynchronous reset in the middle of a stall with REDIRECT high
        drive(1, 0, 0, 0, 1, 32'd64);
        tick();
        tick();
        #1;
        chk("pre_reset_redirect", {31'd0, REDIRECT}, 32'd1);
        #2;
        RESET = 1'b1;
        model_reset();
        #1;
        chk("async_pc", PC, 32'd0);
        chk("async_stall_cnt", STALL_CNT, 32'd0);
        check_now();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] off;
            off = $urandom;
            off[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) off = 32'd0;
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3, off);
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                #1;
                check_now();
                tick();
            end
        end

        // counter wrap on the 4-bit instance (jump with offset 0 every cycle)
        w_reset = 1'b0;
        repeat (16) @(posedge CLK);
        @(negedge CLK);
        chk("wrap_ret_full", {28'd0, w_ret}, 32'd15);
        chk("wrap_red_full", {28'd0, w_red}, 32'd15);
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap_ret_zero", {28'd0, w_ret}, 32'd0);
        chk("wrap_red_zero", {28'd0, w_red}, 32'd0);
        chk("wrap_stall", {28'd0, w_stl}, 32'd0);
        chk("wrap_pc", w_pc, 32'h0000_0140);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
